mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Pipeline stage directly downstream of execute: consumes the executed operation (decoded_op_t) and performs loads/stores on the data-memory bus.
- Forwards a completed operation, including load data, to writeback.
- Non-memory ops pass through with 1-cycle latency.
- Memory ops stall upstream via o_ex_ready until the bus transaction completes.

Parameters:
wd_regs_p, 32, register/data/address width (only 32 supported)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
i_ex_valid  input  1  executed op valid
o_ex_ready  output  1  stage can accept an op this cycle
i_ex_op  input  decoded_op_t  executed op; .result = ALU result/address, .arg2 = store data
o_dmem_req  output  1  bus request
i_dmem_gnt  input  1  request accepted this cycle
o_dmem_we  output  1  1 = store
o_dmem_addr  output  wd_regs_p  word-aligned address (addr[1:0] forced 0)
o_dmem_be  output  4  byte enables
o_dmem_wdata  output  wd_regs_p  lane-replicated store data
i_dmem_rvalid  input  1  load data valid
i_dmem_rdata  input  wd_regs_p  load data word
o_wb_valid  output  1  registered pulse, op complete
o_wb_op  output  decoded_op_t  completed op; .result = load data for loads
o_misaligned  output  1  pulses together with o_wb_valid for a misaligned access

Behaviour:
- Reset: state IDLE, o_wb_valid=0, o_misaligned=0, o_dmem_req=0, o_wb_op='0. Reset mid-transaction abandons it; any later rvalid is ignored.
- FSM states: IDLE, REQ, RSP.
- o_ex_ready = (state==IDLE). It depends on state only, never on bus inputs.
- IDLE, handshake i_ex_valid & o_ex_ready:
  - Non-memory op: next cycle o_wb_valid=1 and o_wb_op=i_ex_op. Stay in IDLE (throughput 1/cycle).
  - Misaligned memory op: next cycle o_wb_valid=1, o_misaligned=1, o_wb_op.rd_we=0. No bus request.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Aligned memory op: latch the op and go to REQ.
- REQ:
  - o_dmem_req=1; addr/be/wdata/we come from the latched op and are held stable until gnt.
  - On gnt, store: o_wb_valid next cycle, go to IDLE.
  - On gnt, load: go to RSP.
  - gnt & rvalid in the same cycle for a load completes directly (as RSP).
  - rvalid without gnt in REQ is ignored.
- RSP:
  - o_dmem_req=0. Wait for rvalid.
  - On rvalid: select lane by addr[1:0], sign- or zero-extend per mem_unsigned, write into .result. o_wb_valid next cycle, go to IDLE.
- Byte enables and write data:
  - Byte: be = 4'b0001<<addr[1:0], wdata = {4{arg2[7:0]}}.
  - Half: be = 4'b0011<<addr[1:0], wdata = {2{arg2[15:0]}}.
  - Word: be = 4'hF, wdata = arg2.
- Load extraction:
  - Byte: lane = rdata[8*addr[1:0]+:8].
  - Half: rdata[16*addr[1]+:16].
- Stores leave .result unchanged and force rd_we=0.
- o_wb_valid and o_misaligned are single-cycle pulses, 0 otherwise. o_wb_op holds its last value when o_wb_valid=0.
- Minimum latency from accept to o_wb_valid:
  - non-mem: 1 cycle
  - store: 2 cycles (gnt in first REQ cycle)
  - load: 2 cycles with gnt&rvalid together, 3 cycles otherwise
- Unbounded gnt/rvalid wait: the stage stalls indefinitely. There is no timeout.

Decomposition:
- Shared package:
  - decoded_op_t must carry is_load, is_store, mem_size (2-bit enum MEM_B/MEM_H/MEM_W), mem_unsigned, rd, rd_we, result, arg2.
  - FSM state enum mem_state_t.
- One sub-module: mem_align (combinational). Produces be/wdata/misaligned from size+addr+data, and load extract/extend from size+unsigned+addr+rdata. It is shared by the store and load paths.

Test Plan:
- ALU op result=0x1234 accepted -> next cycle o_wb_valid=1, result=0x1234, o_ex_ready stays 1; 3 back-to-back ALU ops -> 3 consecutive wb pulses.
- sb arg2=0xAABBCCDD addr=0x103, gnt delayed 2 cycles -> req held 3 cycles, addr=0x100, be=0x8, wdata=0xDDDDDDDD; wb pulse after gnt, rd_we=0.
- lb/lbu addr=0x102, rdata=0x00800000 -> result 0xFFFFFF80 / 0x00000080; lh addr=0x102 rdata=0x80010000 -> 0xFFFF8001.
- lw addr=0x200 with gnt&rvalid same cycle, rdata=0xCAFEF00D -> wb 2 cycles after accept, result=0xCAFEF00D.
- lw addr=0x202 -> no req, next cycle o_wb_valid=1, o_misaligned=1, rd_we=0.
- rst asserted in RSP, then stray rvalid -> outputs at reset values, no wb pulse, o_ex_ready=1.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access stage: the executed-op record, access size and FSM state.
// No logic here; imported by mem_align and mem_access.
package mem_access_pkg;

  localparam int unsigned WD_REGS = 32;
  localparam int unsigned WD_RIDX = 5;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic               is_load;
    logic               is_store;
    mem_size_t          mem_size;
    logic               mem_unsigned;
    logic [WD_RIDX-1:0] rd;
    logic               rd_we;
    logic [WD_REGS-1:0] result;
    logic [WD_REGS-1:0] arg2;
  } decoded_op_t;

  function automatic logic is_mem_op(input decoded_op_t op);
    return op.is_load | op.is_store;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store byte-enables/replicated data, misalignment check,
// and load lane selection with sign/zero extension. Zero latency, no flow control.
module mem_align
  import mem_access_pkg::*;
(
  input  mem_size_t           size,
  input  logic [1:0]          addr_lo,
  input  logic [WD_REGS-1:0]  st_data,
  input  logic                ld_unsigned,
  input  logic [WD_REGS-1:0]  rdata,
  output logic [3:0]          be,
  output logic [WD_REGS-1:0]  wdata,
  output logic                misaligned,
  output logic [WD_REGS-1:0]  ld_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be         = 4'hF;
    wdata      = st_data;
    misaligned = 1'b0;
    ld_data    = rdata;
    case (size)
      MEM_B: begin
        be      = 4'b0001 << addr_lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = ld_unsigned ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      end
      MEM_H: begin
        be         = 4'b0011 << addr_lo;
        wdata      = {2{st_data[15:0]}};
        misaligned = addr_lo[0];
        ld_data    = ld_unsigned ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory stage: non-mem ops pass in 1 cycle; loads/stores run IDLE->REQ(->RSP) on the dmem bus.
// Latency 1 (non-mem/misaligned), 2 (store, load with gnt&rvalid), 3+ (load); o_ex_ready low outside IDLE.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned wd_regs_p = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_ex_valid,
  output logic                 o_ex_ready,
  input  decoded_op_t          i_ex_op,
  output logic                 o_dmem_req,
  input  logic                 i_dmem_gnt,
  output logic                 o_dmem_we,
  output logic [wd_regs_p-1:0] o_dmem_addr,
  output logic [3:0]           o_dmem_be,
  output logic [wd_regs_p-1:0] o_dmem_wdata,
  input  logic                 i_dmem_rvalid,
  input  logic [wd_regs_p-1:0] i_dmem_rdata,
  output logic                 o_wb_valid,
  output decoded_op_t          o_wb_op,
  output logic                 o_misaligned
);

  mem_state_t  state_q, state_d;
  decoded_op_t op_q, op_d;
  decoded_op_t wb_op_q, wb_op_d;
  logic        wb_valid_q, wb_valid_d;
  logic        misaligned_q, misaligned_d;

  // One aligner serves both paths: in IDLE it checks the incoming op, otherwise the latched one.
  decoded_op_t      align_op;
  logic [3:0]       align_be;
  logic [WD_REGS-1:0] align_wdata;
  logic [WD_REGS-1:0] align_ld_data;
  logic             align_mis;

  assign align_op = (state_q == IDLE) ? i_ex_op : op_q;

  mem_align u_align (
    .size        (align_op.mem_size),
    .addr_lo     (align_op.result[1:0]),
    .st_data     (align_op.arg2),
    .ld_unsigned (align_op.mem_unsigned),
    .rdata       (i_dmem_rdata),
    .be          (align_be),
    .wdata       (align_wdata),
    .misaligned  (align_mis),
    .ld_data     (align_ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      wb_op_q      <= '0;
      wb_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wb_op_q      <= wb_op_d;
      wb_valid_q   <= wb_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wb_op_d      = wb_op_q;
    wb_valid_d   = 1'b0;
    misaligned_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_ex_valid) begin
          if (!is_mem_op(i_ex_op)) begin
            wb_valid_d = 1'b1;
            wb_op_d    = i_ex_op;
          end else if (align_mis) begin
            wb_valid_d   = 1'b1;
            misaligned_d = 1'b1;
            wb_op_d      = i_ex_op;
            wb_op_d.rd_we = 1'b0;
          end else begin
            op_d    = i_ex_op;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (i_dmem_gnt) begin
          if (op_q.is_store) begin
            wb_valid_d    = 1'b1;
            wb_op_d       = op_q;
            wb_op_d.rd_we = 1'b0;
            state_d       = IDLE;
          end else if (i_dmem_rvalid) begin
            wb_valid_d     = 1'b1;
            wb_op_d        = op_q;
            wb_op_d.result = align_ld_data;
            state_d        = IDLE;
          end else begin
            state_d = RSP;
          end
        end
      end
      RSP: begin
        if (i_dmem_rvalid) begin
          wb_valid_d     = 1'b1;
          wb_op_d        = op_q;
          wb_op_d.result = align_ld_data;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ex_ready   = (state_q == IDLE);
    o_dmem_req   = (state_q == REQ);
    o_dmem_we    = op_q.is_store;
    o_dmem_addr  = {op_q.result[WD_REGS-1:2], 2'b00};
    o_dmem_be    = align_be;
    o_dmem_wdata = align_wdata;
    o_wb_valid   = wb_valid_q;
    o_wb_op      = wb_op_q;
    o_misaligned = misaligned_q;
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU pass-through, stores, loads, misalignment and reset abort.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ex_valid;
  logic        o_ex_ready;
  decoded_op_t i_ex_op;
  logic        o_dmem_req;
  logic        i_dmem_gnt;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [3:0]  o_dmem_be;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
  logic        o_wb_valid;
  decoded_op_t o_wb_op;
  logic        o_misaligned;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access #(.wd_regs_p(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_ex_valid   (i_ex_valid),
    .o_ex_ready   (o_ex_ready),
    .i_ex_op      (i_ex_op),
    .o_dmem_req   (o_dmem_req),
    .i_dmem_gnt   (i_dmem_gnt),
    .o_dmem_we    (o_dmem_we),
    .o_dmem_addr  (o_dmem_addr),
    .o_dmem_be    (o_dmem_be),
    .o_dmem_wdata (o_dmem_wdata),
    .i_dmem_rvalid(i_dmem_rvalid),
    .i_dmem_rdata (i_dmem_rdata),
    .o_wb_valid   (o_wb_valid),
    .o_wb_op      (o_wb_op),
    .o_misaligned (o_misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic decoded_op_t mk(input logic ld, input logic st, input mem_size_t sz,
                                     input logic uns, input logic [31:0] res, input logic [31:0] a2);
    decoded_op_t op;
    op = '0;
    op.is_load      = ld;
    op.is_store     = st;
    op.mem_size     = sz;
    op.mem_unsigned = uns;
    op.rd           = 5'd7;
    op.rd_we        = 1'b1;
    op.result       = res;
    op.arg2         = a2;
    return op;
  endfunction

  // Issue a load; gnt on the first REQ cycle, rvalid either with gnt or one cycle later.
  task automatic do_load(input string tag, input decoded_op_t op, input logic together,
                         input logic [31:0] rdata, input logic [31:0] exp);
    i_ex_valid = 1'b1; i_ex_op = op;
    step();
    i_ex_valid = 1'b0;
    chk({tag, "_req"}, 32'(o_dmem_req), 32'd1);
    chk({tag, "_we"}, 32'(o_dmem_we), 32'd0);
    i_dmem_gnt = 1'b1;
    if (together) begin i_dmem_rvalid = 1'b1; i_dmem_rdata = rdata; end
    step();
    i_dmem_gnt = 1'b0;
    i_dmem_rvalid = 1'b0;
    if (!together) begin
      chk({tag, "_rsp_wbv"}, 32'(o_wb_valid), 32'd0);
      chk({tag, "_rsp_req"}, 32'(o_dmem_req), 32'd0);
      i_dmem_rvalid = 1'b1; i_dmem_rdata = rdata;
      step();
      i_dmem_rvalid = 1'b0;
    end
    chk({tag, "_wbv"}, 32'(o_wb_valid), 32'd1);
    chk({tag, "_res"}, o_wb_op.result, exp);
    chk({tag, "_rdwe"}, 32'(o_wb_op.rd_we), 32'd1);
    chk({tag, "_rdy"}, 32'(o_ex_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; i_ex_valid = 1'b0; i_ex_op = '0;
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_wbv", 32'(o_wb_valid), 32'd0);
    chk("rst_mis", 32'(o_misaligned), 32'd0);
    chk("rst_req", 32'(o_dmem_req), 32'd0);
    chk("rst_rdy", 32'(o_ex_ready), 32'd1);
    chk("rst_res", o_wb_op.result, 32'd0);

    // ALU pass-through, single then back-to-back
    i_ex_valid = 1'b1; i_ex_op = mk(0, 0, MEM_W, 0, 32'h1234, 32'h0);
    step();
    chk("alu_wbv", 32'(o_wb_valid), 32'd1);
    chk("alu_res", o_wb_op.result, 32'h1234);
    chk("alu_rdy", 32'(o_ex_ready), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      i_ex_op = mk(0, 0, MEM_W, 0, 32'h11 * i, 32'h0);
      step();
      chk("b2b_wbv", 32'(o_wb_valid), 32'd1);
      chk("b2b_res", o_wb_op.result, 32'h11 * i);
    end
    i_ex_valid = 1'b0;
    step();
    chk("alu_idle_wbv", 32'(o_wb_valid), 32'd0);

    // sb to 0x103, grant arrives on the third REQ cycle
    i_ex_valid = 1'b1; i_ex_op = mk(0, 1, MEM_B, 0, 32'h103, 32'hAABBCCDD);
    step();
    i_ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sb_req", 32'(o_dmem_req), 32'd1);
      chk("sb_addr", o_dmem_addr, 32'h100);
      chk("sb_be", 32'(o_dmem_be), 32'h8);
      chk("sb_wdata", o_dmem_wdata, 32'hDDDDDDDD);
      chk("sb_rdy", 32'(o_ex_ready), 32'd0);
      chk("sb_wbv_wait", 32'(o_wb_valid), 32'd0);
      if (i == 2) i_dmem_gnt = 1'b1;
      else step();
    end
    chk("sb_we", 32'(o_dmem_we), 32'd1);
    step();
    i_dmem_gnt = 1'b0;
    chk("sb_wbv", 32'(o_wb_valid), 32'd1);
    chk("sb_rdwe", 32'(o_wb_op.rd_we), 32'd0);
    chk("sb_res", o_wb_op.result, 32'h103);
    chk("sb_req_done", 32'(o_dmem_req), 32'd0);

    // sh to 0x102 with immediate grant: 2-cycle store latency
    i_ex_valid = 1'b1; i_ex_op = mk(0, 1, MEM_H, 0, 32'h102, 32'h11225566);
    step();
    i_ex_valid = 1'b0;
    chk("sh_be", 32'(o_dmem_be), 32'hC);
    chk("sh_wdata", o_dmem_wdata, 32'h55665566);
    chk("sh_wbv_early", 32'(o_wb_valid), 32'd0);
    i_dmem_gnt = 1'b1;
    step();
    i_dmem_gnt = 1'b0;
    chk("sh_wbv", 32'(o_wb_valid), 32'd1);

    // Loads
    do_load("lb",  mk(1, 0, MEM_B, 0, 32'h102, 0), 1'b0, 32'h00800000, 32'hFFFFFF80);
    do_load("lbu", mk(1, 0, MEM_B, 1, 32'h102, 0), 1'b0, 32'h00800000, 32'h00000080);
    do_load("lh",  mk(1, 0, MEM_H, 0, 32'h102, 0), 1'b0, 32'h80010000, 32'hFFFF8001);
    do_load("lhu", mk(1, 0, MEM_H, 1, 32'h100, 0), 1'b1, 32'h1234F00D, 32'h0000F00D);
    do_load("lw",  mk(1, 0, MEM_W, 0, 32'h200, 0), 1'b1, 32'hCAFEF00D, 32'hCAFEF00D);

    // rvalid without gnt in REQ must be ignored
    i_ex_valid = 1'b1; i_ex_op = mk(1, 0, MEM_W, 0, 32'h204, 0);
    step();
    i_ex_valid = 1'b0;
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hBAD0BAD0;
    step();
    i_dmem_rvalid = 1'b0;
    chk("stray_wbv", 32'(o_wb_valid), 32'd0);
    chk("stray_req", 32'(o_dmem_req), 32'd1);
    i_dmem_gnt = 1'b1; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h01020304;
    step();
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0;
    chk("stray_res", o_wb_op.result, 32'h01020304);

    // Misaligned word and half
    i_ex_valid = 1'b1; i_ex_op = mk(1, 0, MEM_W, 0, 32'h202, 0);
    step();
    chk("mis_w_req", 32'(o_dmem_req), 32'd0);
    chk("mis_w_wbv", 32'(o_wb_valid), 32'd1);
    chk("mis_w_mis", 32'(o_misaligned), 32'd1);
    chk("mis_w_rdwe", 32'(o_wb_op.rd_we), 32'd0);
    i_ex_op = mk(0, 1, MEM_H, 0, 32'h101, 32'h5);
    step();
    i_ex_valid = 1'b0;
    chk("mis_h_mis", 32'(o_misaligned), 32'd1);
    chk("mis_h_req", 32'(o_dmem_req), 32'd0);
    step();
    chk("mis_pulse_wbv", 32'(o_wb_valid), 32'd0);
    chk("mis_pulse_mis", 32'(o_misaligned), 32'd0);

    // Reset while waiting in RSP, then a stray rvalid
    i_ex_valid = 1'b1; i_ex_op = mk(1, 0, MEM_W, 0, 32'h300, 0);
    step();
    i_ex_valid = 1'b0;
    i_dmem_gnt = 1'b1;
    step();
    i_dmem_gnt = 1'b0;
    chk("rsp_rdy", 32'(o_ex_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hDEADBEEF;
    step();
    i_dmem_rvalid = 1'b0;
    chk("abort_wbv", 32'(o_wb_valid), 32'd0);
    chk("abort_rdy", 32'(o_ex_ready), 32'd1);
    chk("abort_req", 32'(o_dmem_req), 32'd0);
    chk("abort_res", o_wb_op.result, 32'd0);
    step();
    chk("abort_wbv2", 32'(o_wb_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
